// File: rtl/test_pkg.sv
// Shared constants, state encoding and helpers for the loopback test frame receiver.
package test_pkg;

  localparam logic [15:0] ETH_TYPE_TEST     = 16'h88B5;
  localparam logic [47:0] MAC_LOCAL_DEFAULT = 48'h02_00_00_00_00_00;
  localparam logic [47:0] MAC_BROADCAST     = 48'hFF_FF_FF_FF_FF_FF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  typedef struct packed {
    logic len_err;
    logic data_err;
    logic user_err;
  } eof_flags_t;

  function automatic logic mac_accept(input logic [47:0] dest, input logic [47:0] local_mac);
    return (dest == local_mac) || (dest == MAC_BROADCAST);
  endfunction

endpackage

// File: rtl/test_pattern_check.sv
// Incrementing-pattern datapath: seeds from the first beat, then flags any enabled byte that
// differs from the running expectation.
module test_pattern_check
  import test_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = 0,
  parameter int KEEP_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat,
  input  logic                  first,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic [KEEP_WIDTH-1:0] tkeep,
  output logic                  mismatch
);

  logic [DATA_WIDTH-1:0] exp_data;
  logic [DATA_WIDTH-1:0] byte_mask;

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      byte_mask[i*8 +: 8] = (KEEP_ENABLE != 0) ? {8{tkeep[i]}} : 8'hFF;
  end

  // The first beat only seeds the expectation, so it can never mismatch.
  assign mismatch = beat && !first && (|((tdata ^ exp_data) & byte_mask));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      exp_data <= '0;
    else if (beat)
      exp_data <= first ? tdata + DATA_WIDTH'(1) : exp_data + DATA_WIDTH'(1);
  end

endmodule

// File: rtl/test_receiver.sv
// Receive-side loopback checker: filters headers, verifies payload pattern and length, and keeps
// wrapping statistics counters.
module test_receiver
  import test_pkg::*;
#(
  parameter int          LENGTH      = 512,
  parameter logic [47:0] LOCAL_MAC   = MAC_LOCAL_DEFAULT,
  parameter logic [15:0] ETH_TYPE    = ETH_TYPE_TEST,
  parameter int          DATA_WIDTH  = 8,
  parameter int          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int          KEEP_WIDTH  = (DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic [31:0]           frame_count,
  output logic [31:0]           good_count,
  output logic [31:0]           drop_count,
  output logic [31:0]           data_err_count,
  output logic [31:0]           len_err_count,
  output logic [31:0]           user_err_count,
  output logic [47:0]           last_src_mac,
  output logic                  error_pulse
);

  localparam int LENGTH_BITS = (LENGTH > 1) ? $clog2(LENGTH + 1) : 1;
  localparam int CNT_W       = LENGTH_BITS + 2;

  logic [1:0]       state;
  logic             first_beat;
  logic             data_err;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_next;
  logic             hdr_fire;
  logic             beat_fire;
  logic             check_beat;
  logic             mismatch;
  eof_flags_t       eof;

  assign s_eth_hdr_ready           = (state == ST_IDLE);
  assign s_eth_payload_axis_tready = (state != ST_IDLE);

  assign hdr_fire   = s_eth_hdr_valid && s_eth_hdr_ready;
  assign beat_fire  = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
  assign check_beat = beat_fire && (state == ST_CHECK);

  assign beat_cnt_next = (&beat_cnt) ? beat_cnt : beat_cnt + CNT_W'(1);

  // Verdict for the frame as it would close on this beat, including the beat itself.
  assign eof.len_err  = (LENGTH != 0) && (beat_cnt_next != CNT_W'(LENGTH));
  assign eof.data_err = data_err || mismatch;
  assign eof.user_err = s_eth_payload_axis_tuser;

  test_pattern_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .KEEP_ENABLE (KEEP_ENABLE),
    .KEEP_WIDTH  (KEEP_WIDTH)
  ) u_pattern (
    .clk      (clk),
    .rst      (rst),
    .beat     (check_beat),
    .first    (first_beat),
    .tdata    (s_eth_payload_axis_tdata),
    .tkeep    (s_eth_payload_axis_tkeep),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      first_beat     <= 1'b0;
      data_err       <= 1'b0;
      beat_cnt       <= '0;
      frame_count    <= '0;
      good_count     <= '0;
      drop_count     <= '0;
      data_err_count <= '0;
      len_err_count  <= '0;
      user_err_count <= '0;
      last_src_mac   <= '0;
      error_pulse    <= 1'b0;
    end else begin
      error_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hdr_fire) begin
            frame_count  <= frame_count + 32'd1;
            last_src_mac <= s_eth_src_mac;
            first_beat   <= 1'b1;
            data_err     <= 1'b0;
            beat_cnt     <= '0;
            if ((s_eth_type == ETH_TYPE) && mac_accept(s_eth_dest_mac, LOCAL_MAC)) begin
              state <= ST_CHECK;
            end else begin
              drop_count <= drop_count + 32'd1;
              state      <= ST_DROP;
            end
          end
        end
        ST_CHECK: begin
          if (beat_fire) begin
            first_beat <= 1'b0;
            beat_cnt   <= beat_cnt_next;
            if (mismatch) data_err <= 1'b1;
            if (s_eth_payload_axis_tlast) begin
              state <= ST_IDLE;
              if (eof.len_err)  len_err_count  <= len_err_count + 32'd1;
              if (eof.data_err) data_err_count <= data_err_count + 32'd1;
              if (eof.user_err) user_err_count <= user_err_count + 32'd1;
              if (eof == '0)    good_count     <= good_count + 32'd1;
              error_pulse <= |eof;
            end
          end
        end
        ST_DROP: begin
          if (beat_fire && s_eth_payload_axis_tlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_receiver.sv
// Randomized scoreboard bench for test_receiver: a frame-level model predicts each frame's
// verdict and a monitor compares it against counter movement and error_pulse.
module tb_test_receiver;

  localparam int          LENGTH = 4;
  localparam logic [47:0] LOCAL  = 48'h02_00_00_00_00_00;
  localparam logic [47:0] BCAST  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER  = 48'h02_00_00_00_00_01;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic len_err;
    logic data_err;
    logic user_err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [47:0] dest_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] eth_type = '0;
  logic [7:0]  tdata = '0;
  logic [0:0]  tkeep = 1'b1;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic [31:0] frame_count, good_count, drop_count, data_err_count, len_err_count, user_err_count;
  logic [47:0] last_src_mac;
  logic        error_pulse;

  always #4 clk = ~clk;

  test_receiver #(
    .LENGTH      (LENGTH),
    .LOCAL_MAC   (LOCAL),
    .ETH_TYPE    (16'h88B5),
    .DATA_WIDTH  (8),
    .KEEP_ENABLE (0),
    .KEEP_WIDTH  (1)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_eth_hdr_valid           (hdr_valid),
    .s_eth_hdr_ready           (hdr_ready),
    .s_eth_dest_mac            (dest_mac),
    .s_eth_src_mac             (src_mac),
    .s_eth_type                (eth_type),
    .s_eth_payload_axis_tdata  (tdata),
    .s_eth_payload_axis_tkeep  (tkeep),
    .s_eth_payload_axis_tvalid (tvalid),
    .s_eth_payload_axis_tready (tready),
    .s_eth_payload_axis_tlast  (tlast),
    .s_eth_payload_axis_tuser  (tuser),
    .frame_count               (frame_count),
    .good_count                (good_count),
    .drop_count                (drop_count),
    .data_err_count            (data_err_count),
    .len_err_count             (len_err_count),
    .user_err_count            (user_err_count),
    .last_src_mac              (last_src_mac),
    .error_pulse               (error_pulse)
  );

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  int unsigned m_frames = 0, m_drops = 0, m_good = 0, m_len = 0, m_data = 0, m_user = 0;
  logic [47:0] m_src = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any end-of-frame counter movement retires one scoreboard entry.
  logic [31:0] pg = '0, pl = '0, pd = '0, pu = '0;
  always @(negedge clk) begin
    logic [31:0] dg, dl, dd, du;
    exp_t e;
    if (rst) begin
      pg = '0; pl = '0; pd = '0; pu = '0;
    end else begin
      dg = good_count - pg;
      dl = len_err_count - pl;
      dd = data_err_count - pd;
      du = user_err_count - pu;
      if ((dg | dl | dd | du) != 0) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("eof_result",
                {dg[3:0], dl[3:0], dd[3:0], du[3:0], 3'b0, error_pulse},
                {4'((e == '0) ? 1 : 0), 4'(e.len_err), 4'(e.data_err), 4'(e.user_err), 3'b0, |e});
        end
      end else if (error_pulse) begin
        check("stray_error_pulse", 64'(error_pulse), 64'd0);
      end
      pg = good_count; pl = len_err_count; pd = data_err_count; pu = user_err_count;
    end
  end

  task automatic wait_hdr_ready();
    int n = 0;
    while (!hdr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!hdr_ready) check("hdr_ready_timeout", 64'(hdr_ready), 64'd1);
  endtask

  task automatic wait_tready();
    int n = 0;
    while (!tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tready) check("tready_timeout", 64'(tready), 64'd1);
  endtask

  // Predicts the verdict from frame-level rules, then drives the frame with random gaps.
  task automatic send_frame(input logic [47:0] dest, input logic [15:0] etype, input bq_t d,
                            input logic user, input int max_gap);
    logic [47:0] src;
    exp_t e;
    src = {16'h0A00, 32'($urandom)};
    m_frames++;
    m_src = src;
    if (etype != 16'h88B5 || (dest != LOCAL && dest != BCAST)) begin
      m_drops++;
    end else begin
      e.len_err  = (d.size() != LENGTH);
      e.data_err = 1'b0;
      for (int i = 1; i < d.size(); i++)
        if (d[i] != 8'(d[0] + i)) e.data_err = 1'b1;
      e.user_err = user;
      sb.push_back(e);
      if (e == '0) m_good++;
      if (e.len_err) m_len++;
      if (e.data_err) m_data++;
      if (e.user_err) m_user++;
    end

    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    hdr_valid = 1'b1;
    dest_mac  = dest;
    eth_type  = etype;
    src_mac   = src;
    wait_hdr_ready();
    @(negedge clk);
    hdr_valid = 1'b0;
    src_mac   = {16'hDEAD, 32'($urandom)};
    for (int i = 0; i < d.size(); i++) begin
      tvalid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      tvalid = 1'b1;
      tdata  = d[i];
      tlast  = (i == d.size() - 1);
      tuser  = tlast ? user : 1'($urandom);
      wait_tready();
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  function automatic bq_t ramp(input logic [7:0] start, input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'(start + i));
    return q;
  endfunction

  task automatic check_totals(input string tag);
    int n = 0;
    repeat (3) @(negedge clk);
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    check({tag, "_frame_count"}, 64'(frame_count), 64'(m_frames));
    check({tag, "_good_count"}, 64'(good_count), 64'(m_good));
    check({tag, "_drop_count"}, 64'(drop_count), 64'(m_drops));
    check({tag, "_data_err_count"}, 64'(data_err_count), 64'(m_data));
    check({tag, "_len_err_count"}, 64'(len_err_count), 64'(m_len));
    check({tag, "_user_err_count"}, 64'(user_err_count), 64'(m_user));
    check({tag, "_last_src_mac"}, 64'(last_src_mac), 64'(m_src));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_counters"},
          64'(frame_count | good_count | drop_count | data_err_count | len_err_count | user_err_count),
          64'd0);
    check({tag, "_last_src_mac"}, 64'(last_src_mac), 64'd0);
    check({tag, "_error_pulse"}, 64'(error_pulse), 64'd0);
    check({tag, "_hdr_ready"}, 64'(hdr_ready), 64'd1);
    check({tag, "_tready"}, 64'(tready), 64'd0);
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t d;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // Plain good frames, back to back.
    send_frame(LOCAL, 16'h88B5, ramp(8'h00, 4), 1'b0, 0);
    send_frame(LOCAL, 16'h88B5, ramp(8'h04, 4), 1'b0, 0);
    send_frame(LOCAL, 16'h88B5, ramp(8'h08, 4), 1'b0, 0);
    check_totals("t1");

    // Wrong EtherType is dropped silently, even with a broken pattern.
    d = '{8'h00, 8'h55, 8'h00, 8'h99};
    send_frame(LOCAL, 16'h0800, d, 1'b0, 0);
    send_frame(LOCAL, 16'h88B5, ramp(8'h20, 4), 1'b0, 0);
    check_totals("t2");

    d = '{8'h10, 8'h11, 8'h13, 8'h14};
    send_frame(LOCAL, 16'h88B5, d, 1'b0, 0);
    check_totals("t3");

    send_frame(LOCAL, 16'h88B5, ramp(8'h30, 3), 1'b0, 0);
    send_frame(LOCAL, 16'h88B5, ramp(8'h40, 5), 1'b0, 0);
    d = '{8'h50, 8'h51, 8'h52, 8'h00, 8'h54};
    send_frame(LOCAL, 16'h88B5, d, 1'b0, 0);
    check_totals("t4");

    send_frame(LOCAL, 16'h88B5, ramp(8'hFE, 4), 1'b0, 0);
    send_frame(LOCAL, 16'h88B5, ramp(8'h60, 4), 1'b1, 0);
    check_totals("t5");

    // Broadcast accepted, foreign MAC dropped, single-beat frame is pattern-clean but short.
    send_frame(BCAST, 16'h88B5, ramp(8'h70, 4), 1'b0, 1);
    send_frame(OTHER, 16'h88B5, ramp(8'h80, 4), 1'b0, 1);
    send_frame(LOCAL, 16'h88B5, ramp(8'h90, 1), 1'b0, 1);
    check_totals("edges");

    for (int f = 0; f < 40; f++) begin
      logic [47:0] dst;
      logic [15:0] ty;
      int len;
      int sel;
      sel = $urandom_range(9, 0);
      dst = (sel < 6) ? LOCAL : (sel < 8) ? BCAST : OTHER;
      ty  = ($urandom_range(9, 0) == 0) ? 16'h0800 : 16'h88B5;
      len = $urandom_range(6, 1);
      d = ramp(8'($urandom), len);
      if (len > 1 && $urandom_range(3, 0) == 0) begin
        int idx;
        idx = $urandom_range(len - 1, 1);
        d[idx] = d[idx] ^ 8'($urandom_range(255, 1));
      end
      send_frame(dst, ty, d, ($urandom_range(4, 0) == 0), 3);
    end
    check_totals("random");

    // Abort a frame mid-CHECK with reset, then show recovery with the source also reset.
    @(negedge clk);
    hdr_valid = 1'b1;
    dest_mac  = LOCAL;
    eth_type  = 16'h88B5;
    src_mac   = 48'h0A00_1234_5678;
    wait_hdr_ready();
    @(negedge clk);
    hdr_valid = 1'b0;
    tvalid = 1'b1;
    tdata  = 8'h00;
    check("midframe_tready", 64'(tready), 64'd1);
    @(negedge clk);
    tdata = 8'h05;
    @(negedge clk);
    rst    = 1'b1;
    tvalid = 1'b0;
    sb.delete();
    m_frames = 0; m_drops = 0; m_good = 0; m_len = 0; m_data = 0; m_user = 0; m_src = '0;
    @(negedge clk);
    check_cleared("midreset");
    rst = 1'b0;
    @(negedge clk);
    send_frame(LOCAL, 16'h88B5, ramp(8'hA0, 4), 1'b0, 2);
    check_totals("recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/test_receiver.md
Name: test_receiver

Overview:
Loopback checker that consumes Ethernet frames (header and payload AXI stream) from the MAC/eth_axis_rx path. It is the receive-side counterpart of the test frame generator. It filters on EtherType and destination MAC and verifies that the payload follows the incrementing-byte pattern and the expected length. It exposes wrapping 32-bit statistics counters for ILA/debug and for status registers.

Parameters:
LENGTH, 512, expected payload beats per frame; 0 disables the length check
LOCAL_MAC, 48'h02_00_00_00_00_00, destination MAC accepted (broadcast FF..FF also accepted)
ETH_TYPE, 16'h88B5, EtherType accepted
DATA_WIDTH, 8, payload tdata width in bits
KEEP_ENABLE, (DATA_WIDTH>8), use tkeep; if 0, tkeep is treated as all ones
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width

Ports:
clk  in  1  system clock, 125 MHz
rst  in  1  synchronous, active-high reset
s_eth_hdr_valid  in  1  header valid
s_eth_hdr_ready  out  1  header ready
s_eth_dest_mac  in  48  destination MAC
s_eth_src_mac  in  48  source MAC (captured, not checked)
s_eth_type  in  16  EtherType
s_eth_payload_axis_tdata  in  DATA_WIDTH  payload data
s_eth_payload_axis_tkeep  in  KEEP_WIDTH  byte enables
s_eth_payload_axis_tvalid  in  1  payload valid
s_eth_payload_axis_tready  out  1  payload ready
s_eth_payload_axis_tlast  in  1  last beat
s_eth_payload_axis_tuser  in  1  bad-frame flag from MAC
frame_count  out  32  headers accepted
good_count  out  32  frames passing all checks
drop_count  out  32  frames rejected on header
data_err_count  out  32  frames with at least one pattern error
len_err_count  out  32  frames with wrong length
user_err_count  out  32  frames with tuser set on tlast
last_src_mac  out  48  src MAC of the last accepted header
error_pulse  out  1  one-cycle pulse when any error counter increments

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - All counters, last_src_mac and error_pulse are 0.
  - State is IDLE.
  - s_eth_hdr_ready = 1 and tready = 0.
- FSM with three states, IDLE, CHECK and DROP:
  - IDLE: hdr_ready = 1, tready = 0. On a header fire:
    - frame_count increments and last_src_mac is captured.
    - If type == ETH_TYPE and (dest == LOCAL_MAC or dest == all-ones), go to CHECK; otherwise drop_count increments and go to DROP.
  - CHECK: hdr_ready = 0, tready = 1.
    - First beat seeds exp = tdata + 1; every later beat must satisfy tdata == exp, and exp then advances by 1 modulo 2^DATA_WIDTH.
    - A mismatch sets the sticky flag data_err.
    - The beat counter (LENGTH_BITS+2 bits) saturates at all-ones.
    - On the tlast fire, return to IDLE.
  - DROP: tready = 1. Beats are discarded without checking; on the tlast fire, return to IDLE.
- KEEP_ENABLE = 1: only bytes whose tkeep bit is set are compared.
- End-of-frame evaluation, on the tlast fire in CHECK:
  - len_err = (LENGTH != 0) && (beat count including the last beat != LENGTH).
  - user_err = tuser.
  - data_err = the sticky flag.
  - Each asserted flag increments its own counter. A frame may increment several counters.
  - good_count increments only if all three flags are clear.
  - Counters and error_pulse update registered, one cycle after the tlast fire.
- A single-beat frame (header, then one beat with tlast) is legal. It has no pattern error and has length 1.
- Counters wrap from 0xFFFFFFFF to 0. They never saturate.
- A header is never accepted on the same cycle as a payload beat. The FSM is strictly serial, with at most one frame in flight.
- Reset mid-frame:
  - The FSM goes to IDLE and the sticky flags and counters clear.
  - Upstream leftover beats are attributed to the next accepted frame. The bench must reset the source as well.

Decomposition:
- Package test_pkg holds:
  - ETH_TYPE_TEST = 16'h88B5
  - the default MACs
  - the state encoding (IDLE, CHECK, DROP)
- Sub-module test_pattern_check holds the seed/expect/compare datapath with tkeep masking. Inputs are beat, first and tdata/tkeep; output is mismatch.
- The FSM and counters stay in test_receiver.

Test Plan:
1. Three frames, type 88B5, dest LOCAL_MAC, LENGTH = 4, data 00..03, 04..07, 08..0B -> frame_count = 3, good_count = 3, all error counters 0.
2. One frame with type 0800, 4 beats, followed by a valid frame -> drop_count = 1, frame_count = 2, good_count = 1; the dropped beats produce no data_err.
3. Valid frame 10,11,13,14 -> data_err_count = 1, good_count = 0, one error_pulse one cycle after tlast.
4. LENGTH = 4, frames of 3 and 5 beats with a correct pattern, plus a 5-beat frame with a bad byte -> len_err_count = 3, data_err_count = 1, good_count = 0.
5. Pattern wrap: data FE,FF,00,01 -> pass. tuser = 1 on tlast -> user_err_count = 1.
6. Random tvalid/hdr_valid gaps, then rst asserted mid-CHECK -> all outputs 0 the cycle after, hdr_ready = 1, tready = 0.
